alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational 64-bit ALU.
- Adds width parameterisation, an iterative one-bit-per-cycle shifter, compare ops, status flags, an error flag, valid/ready on both sides and synchronous flush.
- Sits between operand-fetch and writeback in the multi-cycle datapath.
- Result is held stable until the consumer takes it.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/op request channel and result channel between operand-fetch,
// the sequential ALU and writeback.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_carry;
  logic             out_overflow;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_carry, out_overflow, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_carry, out_overflow, out_err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle arithmetic/logic/compare ops and an
// iterative one-bit-per-cycle shifter; result held until the consumer takes it.
module alu_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic          busy,
  alu_seq_if.slave      bus
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   acc, acc_d, step;
  logic [SHAMT_W-1:0] cnt, cnt_d, shamt;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   res_d;
  logic               zero_d, carry_d, ovf_d, err_d;
  logic               accept, is_shift, shift_go;
  logic [WIDTH-1:0]   b_eff, calc_res;
  logic [WIDTH:0]     sum;
  logic               calc_carry, calc_ovf, calc_err;

  assign shamt    = bus.in_b[SHAMT_W-1:0];
  assign accept   = bus.in_valid && (state == IDLE);
  assign is_shift = (bus.in_op == OP_SLL) || (bus.in_op == OP_SRL) || (bus.in_op == OP_SRA);
  assign shift_go = is_shift && (shamt != '0);

  // Single-cycle result for everything except non-zero shifts
  always_comb begin
    b_eff      = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
    sum        = {1'b0, bus.in_a} + {1'b0, b_eff} + (WIDTH+1)'(bus.in_op == OP_SUB);
    calc_res   = '0;
    calc_carry = 1'b0;
    calc_ovf   = 1'b0;
    calc_err   = 1'b0;
    case (bus.in_op)
      OP_ADD, OP_SUB: begin
        calc_res   = sum[WIDTH-1:0];
        calc_carry = sum[WIDTH];
        calc_ovf   = (bus.in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OP_XOR:                 calc_res = bus.in_a ^ bus.in_b;
      OP_OR:                  calc_res = bus.in_a | bus.in_b;
      OP_AND:                 calc_res = bus.in_a & bus.in_b;
      OP_SLL, OP_SRL, OP_SRA: calc_res = bus.in_a;
      OP_SLT:                 calc_res = WIDTH'($signed(bus.in_a) < $signed(bus.in_b));
      OP_SLTU:                calc_res = WIDTH'(bus.in_a < bus.in_b);
      default:                calc_err = 1'b1;
    endcase
  end

  // One shift step on the accumulator
  always_comb begin
    case (op_q)
      OP_SLL:  step = {acc[WIDTH-2:0], 1'b0};
      OP_SRA:  step = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: step = {1'b0, acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = shift_go ? SHIFT : DONE;
      SHIFT:   if (cnt == SHAMT_W'(1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath next values; flush drops any op being accepted or in flight
  always_comb begin
    acc_d   = acc;
    cnt_d   = cnt;
    op_d    = op_q;
    res_d   = bus.out_result;
    zero_d  = bus.out_zero;
    carry_d = bus.out_carry;
    ovf_d   = bus.out_overflow;
    err_d   = bus.out_err;
    if (flush) begin
      cnt_d = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && shift_go) begin
            acc_d = bus.in_a;
            cnt_d = shamt;
            op_d  = bus.in_op;
          end else if (accept) begin
            res_d   = calc_res;
            zero_d  = (calc_res == '0);
            carry_d = calc_carry;
            ovf_d   = calc_ovf;
            err_d   = calc_err;
          end
        end
        SHIFT: begin
          acc_d = step;
          cnt_d = cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            res_d   = step;
            zero_d  = (step == '0);
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc              <= '0;
      cnt              <= '0;
      op_q             <= '0;
      bus.out_result   <= '0;
      bus.out_zero     <= 1'b0;
      bus.out_carry    <= 1'b0;
      bus.out_overflow <= 1'b0;
      bus.out_err      <= 1'b0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      busy             <= 1'b0;
    end else begin
      acc              <= acc_d;
      cnt              <= cnt_d;
      op_q             <= op_d;
      bus.out_result   <= res_d;
      bus.out_zero     <= zero_d;
      bus.out_carry    <= carry_d;
      bus.out_overflow <= ovf_d;
      bus.out_err      <= err_d;
      bus.in_ready     <= (state_d == IDLE);
      bus.out_valid    <= (state_d == DONE);
      busy             <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 64-bit instance for most scenarios and an
// 8-bit instance for the narrow-width shift case.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic flush64, flush8, busy64, busy8;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if #(.WIDTH(64)) b64 ();
  alu_seq_if #(.WIDTH(8))  b8 ();

  alu_seq #(.WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush64), .busy(busy64), .bus(b64));
  alu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .flush(flush8),  .busy(busy8),  .bus(b8));

  always #5 clk = ~clk;

  // Issue one op on the 64-bit instance, capture the result, let it drain
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                        output logic [63:0] res, output logic [3:0] flg, output int lat);
    b64.in_a = a; b64.in_b = b; b64.in_op = op; b64.in_valid = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    lat = 1;
    while (!b64.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = b64.out_result;
    flg = {b64.out_zero, b64.out_carry, b64.out_overflow, b64.out_err};
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total++; if (b64.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", b64.out_valid); end
    total++; if (b64.out_result !== 64'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", b64.out_result); end
    total++; if ({busy64, b64.out_zero, b64.out_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {busy64, b64.out_zero, b64.out_err}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", b64.in_ready); end
  endtask

  task automatic test_add_sub;
    logic [63:0] res; logic [3:0] flg; int lat;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b0000, res, flg, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
    total++; if (res !== 64'h0) begin bad++; $display("FAIL add_result got=%h exp=0", res); end
    total++; if (flg !== 4'b1100) begin bad++; $display("FAIL add_flags got=%b exp=1100", flg); end
    run_op(64'h8000_0000_0000_0000, 64'h1, 4'b1000, res, flg, lat);
    total++; if (res !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL sub_result got=%h exp=7fffffffffffffff", res); end
    total++; if (flg !== 4'b0110) begin bad++; $display("FAIL sub_flags got=%b exp=0110", flg); end
  endtask

  task automatic test_compare;
    logic [63:0] res; logic [3:0] flg; int lat;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b0010, res, flg, lat);
    total++; if (res !== 64'h1) begin bad++; $display("FAIL slt_result got=%h exp=1", res); end
    total++; if (flg !== 4'b0000) begin bad++; $display("FAIL slt_flags got=%b exp=0000", flg); end
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b0011, res, flg, lat);
    total++; if (res !== 64'h0) begin bad++; $display("FAIL sltu_result got=%h exp=0", res); end
    total++; if (flg !== 4'b1000) begin bad++; $display("FAIL sltu_flags got=%b exp=1000", flg); end
  endtask

  task automatic test_logic_err;
    logic [63:0] res; logic [3:0] flg; int lat;
    run_op(64'hFF00_FF00_0000_00F0, 64'h0F0F_0000_0000_00FF, 4'b0111, res, flg, lat);
    total++; if (res !== 64'h0F00_0000_0000_00F0) begin bad++; $display("FAIL and_result got=%h exp=0f000000000000f0", res); end
    run_op(64'hFF00_0000_0000_0000, 64'h0000_0000_0000_000F, 4'b0110, res, flg, lat);
    total++; if (res !== 64'hFF00_0000_0000_000F) begin bad++; $display("FAIL or_result got=%h exp=ff0000000000000f", res); end
    run_op(64'h1234, 64'h5678, 4'b1111, res, flg, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL err_latency got=%0d exp=1", lat); end
    total++; if (res !== 64'h0) begin bad++; $display("FAIL err_result got=%h exp=0", res); end
    total++; if (flg !== 4'b1001) begin bad++; $display("FAIL err_flags got=%b exp=1001", flg); end
  endtask

  task automatic test_shift;
    logic [63:0] res; logic [3:0] flg; int lat;
    b64.in_a = 64'h8000_0000_0000_0000; b64.in_b = 64'h45; b64.in_op = 4'b1101; b64.in_valid = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0; b64.in_a = '1; b64.in_b = '0; b64.in_op = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      total++; if ({busy64, b64.in_ready, b64.out_valid} !== 3'b100) begin bad++; $display("FAIL sra_busy_cycle%0d got=%b exp=100", i, {busy64, b64.in_ready, b64.out_valid}); end
      @(posedge clk); #1;
    end
    total++; if (b64.out_valid !== 1'b1) begin bad++; $display("FAIL sra_valid got=%b exp=1", b64.out_valid); end
    total++; if (b64.out_result !== 64'hFC00_0000_0000_0000) begin bad++; $display("FAIL sra_result got=%h exp=fc00000000000000", b64.out_result); end
    @(posedge clk); #1;
    run_op(64'h1234, 64'h40, 4'b0001, res, flg, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL sll0_latency got=%0d exp=1", lat); end
    total++; if (res !== 64'h1234) begin bad++; $display("FAIL sll0_result got=%h exp=1234", res); end
    run_op(64'h1234, 64'h4, 4'b0001, res, flg, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL sll4_latency got=%0d exp=5", lat); end
    total++; if (res !== 64'h12340) begin bad++; $display("FAIL sll4_result got=%h exp=12340", res); end
    run_op(64'h8000_0000_0000_0000, 64'h3F, 4'b0101, res, flg, lat);
    total++; if (lat !== 64) begin bad++; $display("FAIL srl63_latency got=%0d exp=64", lat); end
    total++; if (res !== 64'h1) begin bad++; $display("FAIL srl63_result got=%h exp=1", res); end
  endtask

  task automatic test_backpressure;
    b64.out_ready = 1'b0;
    b64.in_a = 64'hF0; b64.in_b = 64'hFF; b64.in_op = 4'b0100; b64.in_valid = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if ({b64.out_valid, b64.in_ready, b64.out_result} !== {2'b10, 64'h0F}) begin bad++; $display("FAIL hold_cycle%0d got=%b/%b/%h exp=1/0/0f", i, b64.out_valid, b64.in_ready, b64.out_result); end
      @(posedge clk); #1;
    end
    b64.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if ({b64.in_ready, b64.out_valid} !== 2'b10) begin bad++; $display("FAIL release got=%b exp=10", {b64.in_ready, b64.out_valid}); end
  endtask

  task automatic test_flush;
    logic [63:0] res; logic [3:0] flg; int lat; logic seen;
    b64.in_a = 64'h1; b64.in_b = 64'd40; b64.in_op = 4'b0001; b64.in_valid = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen |= b64.out_valid; end
    flush64 = 1'b1;
    @(posedge clk); #1;
    flush64 = 1'b0;
    total++; if ({busy64, b64.in_ready, b64.out_valid} !== 3'b010) begin bad++; $display("FAIL flush_idle got=%b exp=010", {busy64, b64.in_ready, b64.out_valid}); end
    repeat (45) begin @(posedge clk); #1; seen |= b64.out_valid; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_valid got=%b exp=0", seen); end
    run_op(64'd2, 64'd3, 4'b0000, res, flg, lat);
    total++; if (res !== 64'd5) begin bad++; $display("FAIL post_flush_add got=%h exp=5", res); end
    total++; if (lat !== 1) begin bad++; $display("FAIL post_flush_latency got=%0d exp=1", lat); end
    // flush together with accept drops the op
    b64.in_a = 64'd1; b64.in_b = 64'd1; b64.in_op = 4'b0000; b64.in_valid = 1'b1; flush64 = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0; flush64 = 1'b0;
    @(posedge clk); #1;
    total++; if ({busy64, b64.out_valid, b64.out_result} !== {2'b00, 64'd5}) begin bad++; $display("FAIL flush_accept got=%b/%b/%h exp=0/0/5", busy64, b64.out_valid, b64.out_result); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] res; logic [3:0] flg; int lat;
    run_op(64'd10, 64'd20, 4'b0000, res, flg, lat);
    total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", b64.in_ready); end
    run_op(64'd100, 64'd1, 4'b1000, res, flg, lat);
    total++; if ({res, lat[3:0]} !== {64'd99, 4'd1}) begin bad++; $display("FAIL b2b_second got=%h lat=%0d exp=63 lat=1", res, lat); end
  endtask

  task automatic test_reset_mid;
    b64.in_a = 64'h1; b64.in_b = 64'd40; b64.in_op = 4'b0001; b64.in_valid = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if ({busy64, b64.out_valid, b64.out_result} !== 66'h0) begin bad++; $display("FAIL rst_mid_shift got=%b/%b/%h exp=0/0/0", busy64, b64.out_valid, b64.out_result); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    b64.out_ready = 1'b0;
    b64.in_a = 64'hF0; b64.in_b = 64'hF0; b64.in_op = 4'b0110; b64.in_valid = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    total++; if ({b64.out_valid, b64.out_result} !== {1'b1, 64'hF0}) begin bad++; $display("FAIL pre_rst_done got=%b/%h exp=1/f0", b64.out_valid, b64.out_result); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({b64.out_valid, b64.out_result, b64.out_zero} !== 66'h0) begin bad++; $display("FAIL rst_mid_done got=%b/%h/%b exp=0/0/0", b64.out_valid, b64.out_result, b64.out_zero); end
    @(posedge clk); #1 rst_n = 1'b1;
    b64.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_w8;
    int lat;
    b8.in_a = 8'h80; b8.in_b = 8'h0B; b8.in_op = 4'b0101; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 1;
    while (!b8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 4) begin bad++; $display("FAIL w8_srl_latency got=%0d exp=4", lat); end
    total++; if (b8.out_result !== 8'h10) begin bad++; $display("FAIL w8_srl_result got=%h exp=10", b8.out_result); end
    @(posedge clk); #1;
  endtask

  initial begin
    flush64 = 1'b0; flush8 = 1'b0;
    b64.in_valid = 1'b0; b64.in_a = '0; b64.in_b = '0; b64.in_op = '0; b64.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.in_op  = '0; b8.out_ready  = 1'b1;
    test_reset;
    test_add_sub;
    test_compare;
    test_logic_err;
    test_shift;
    test_backpressure;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    test_w8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
